// File: rtl/icache_refill_pkg.sv
// Shared constants and types for the instruction-cache miss-refill engine.
// Line geometry lives here so the engine, its interface and benches agree on it.
package icache_pkg;

  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned OFFSET_W   = $clog2(LINE_WORDS);
  localparam int unsigned INDEX_LSB  = 5;
  localparam int unsigned INDEX_W    = 7;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StAr,
    StRd,
    StDone
  } refill_state_e;

endpackage

// File: rtl/icache_refill_if.sv
// AXI4 read address and read data channels used by the refill engine.
// The engine is the master; the memory side or a bench model is the slave.
interface icache_refill_if;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/icache_refill.sv
// Icache line refill: one AXI4 read burst per miss, each beat written to its word bank.
// Define ICACHE_CRIT_WORD_FIRST_EN to fetch the missed word first with a WRAP burst.
module icache_refill
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [31:0]           miss_addr,
  output logic                  miss_ready,
  icache_refill_if.master       axi,
  output logic [LINE_WORDS-1:0] ram_en,
  output logic [3:0]            ram_wen,
  output logic [31:0]           ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  crit_valid,
  output logic [31:0]           crit_data,
  output logic                  refill_done,
  output logic                  refill_err,
  output logic [INDEX_W-1:0]    refill_index
);

  localparam int unsigned WordLsb = INDEX_LSB - OFFSET_W;
  localparam logic [OFFSET_W:0] FullCnt = (OFFSET_W + 1)'(LINE_WORDS);
  localparam logic [LINE_WORDS-1:0] OneBank = {{(LINE_WORDS - 1){1'b0}}, 1'b1};

  refill_state_e         state_q, state_d;
  logic [31:WordLsb]     addr_q, addr_d;
  logic [31:0]           araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic [OFFSET_W-1:0]   bank_q, bank_d;
  logic [OFFSET_W:0]     cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  ready_q;
  logic [LINE_WORDS-1:0] ram_en_q, ram_en_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;
  logic                  crit_valid_q, crit_valid_d;
  logic [31:0]           crit_data_q, crit_data_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    bank_d       = bank_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    ram_en_d     = '0;
    ram_wdata_d  = ram_wdata_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;

    unique case (state_q)
      StIdle: begin
        if (miss_valid && ready_q) begin
          addr_d   = miss_addr[31:WordLsb];
          arlen_d  = 8'(LINE_WORDS - 1);
          arsize_d = SIZE_4B;
          cnt_d    = '0;
          err_d    = 1'b0;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
          araddr_d  = miss_addr & ~32'h3;
          arburst_d = BURST_WRAP;
          bank_d    = miss_addr[WordLsb +: OFFSET_W];
`else
          araddr_d  = miss_addr & ~32'((1 << INDEX_LSB) - 1);
          arburst_d = BURST_INCR;
          bank_d    = '0;
`endif
          state_d = StAr;
        end
      end
      StAr: begin
        if (axi.arready) state_d = StRd;
      end
      StRd: begin
        if (axi.rvalid) begin
          ram_en_d     = OneBank << bank_q;
          ram_wdata_d  = axi.rdata;
          crit_valid_d = (bank_q == addr_q[WordLsb +: OFFSET_W]);
          crit_data_d  = axi.rdata;
          bank_d       = bank_q + 1'b1;
          cnt_d        = cnt_q + 1'b1;
          if (axi.rresp != RESP_OKAY) err_d = 1'b1;
          if (axi.rlast) begin
            state_d = StDone;
            if (cnt_d != FullCnt) err_d = 1'b1;
          end else if (cnt_d == FullCnt) begin
            // Slave overran the line without rlast: stop accepting and flag it.
            state_d = StDone;
            err_d   = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      bank_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      ram_en_q     <= '0;
      ram_wdata_q  <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      bank_q       <= bank_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      ready_q      <= (state_d == StIdle);
      ram_en_q     <= ram_en_d;
      ram_wdata_q  <= ram_wdata_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  assign miss_ready   = ready_q;
  assign axi.arvalid  = (state_q == StAr);
  assign axi.araddr   = araddr_q;
  assign axi.arlen    = arlen_q;
  assign axi.arsize   = arsize_q;
  assign axi.arburst  = arburst_q;
  assign axi.rready   = (state_q == StRd);

  assign ram_en       = ram_en_q;
  assign ram_wen      = (|ram_en_q) ? 4'hF : 4'h0;
  assign ram_addr     = {addr_q[31:INDEX_LSB], {INDEX_LSB{1'b0}}};
  assign ram_wdata    = ram_wdata_q;
  assign crit_valid   = crit_valid_q;
  assign crit_data    = crit_data_q;
  assign refill_done  = (state_q == StDone);
  assign refill_err   = refill_done & err_q;
  assign refill_index = refill_done ? addr_q[INDEX_LSB +: INDEX_W] : '0;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: reset, basic refill, backpressure and error cases.
// Expectations follow ICACHE_CRIT_WORD_FIRST_EN when the bench is built with it.
module tb_icache_refill;
  import icache_pkg::*;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
  localparam bit Cwf = 1'b1;
`else
  localparam bit Cwf = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  miss_valid = 1'b0;
  logic [31:0]           miss_addr = '0;
  logic                  miss_ready;
  logic [LINE_WORDS-1:0] ram_en;
  logic [3:0]            ram_wen;
  logic [31:0]           ram_addr;
  logic [31:0]           ram_wdata;
  logic                  crit_valid;
  logic [31:0]           crit_data;
  logic                  refill_done;
  logic                  refill_err;
  logic [INDEX_W-1:0]    refill_index;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  icache_refill_if axi ();

  icache_refill dut (
    .clk          (clk),
    .rst          (rst),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .miss_ready   (miss_ready),
    .axi          (axi.master),
    .ram_en       (ram_en),
    .ram_wen      (ram_wen),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .crit_valid   (crit_valid),
    .crit_data    (crit_data),
    .refill_done  (refill_done),
    .refill_err   (refill_err),
    .refill_index (refill_index)
  );

  // Event log filled at every falling edge; tasks index it from a saved base.
  logic [7:0]  wr_en   [0:255];
  logic [31:0] wr_data [0:255];
  logic [6:0]  wr_idx  [0:255];
  logic [3:0]  wr_wen  [0:255];
  int          wr_cnt = 0;
  int          crit_cnt = 0;
  int          crit_pos = 0;
  logic [31:0] crit_d = '0;
  int          done_cnt = 0;
  int          done_pos = 0;
  logic        done_wr = 1'b0;
  logic        done_err = 1'b0;
  logic [6:0]  done_idx = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (ram_en != '0) begin
        wr_en[wr_cnt[7:0]]   <= ram_en;
        wr_data[wr_cnt[7:0]] <= ram_wdata;
        wr_idx[wr_cnt[7:0]]  <= ram_addr[11:5];
        wr_wen[wr_cnt[7:0]]  <= ram_wen;
        wr_cnt               <= wr_cnt + 1;
      end
      if (crit_valid) begin
        crit_cnt <= crit_cnt + 1;
        crit_d   <= crit_data;
        crit_pos <= wr_cnt;
      end
      if (refill_done) begin
        done_cnt <= done_cnt + 1;
        done_err <= refill_err;
        done_idx <= refill_index;
        done_pos <= wr_cnt;
        done_wr  <= (ram_en != '0);
      end
    end
  end

  logic [31:0] obs_araddr;
  logic [7:0]  obs_arlen;
  logic [1:0]  obs_arburst;
  logic [2:0]  obs_arsize;
  bit          ar_stable;
  bit          rready_after;
  int          not_ready_beats;
  int          wr_base, crit_base, done_base;

  task automatic do_refill(input logic [31:0] a, input int ar_delay, input bit gap,
                           input int err_beat, input int last_beat, input int nbeats,
                           input int abort_at);
    int t;
    wr_base = wr_cnt; crit_base = crit_cnt; done_base = done_cnt;
    not_ready_beats = 0;
    miss_valid = 1'b1;
    miss_addr  = a;
    t = 0;
    while (!miss_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    miss_valid = 1'b0;
    miss_addr  = '0;
    obs_araddr  = axi.araddr;
    obs_arlen   = axi.arlen;
    obs_arburst = axi.arburst;
    obs_arsize  = axi.arsize;
    ar_stable   = axi.arvalid;
    for (int i = 0; i < ar_delay; i++) begin
      @(posedge clk); #1;
      if (!axi.arvalid || axi.araddr !== obs_araddr || axi.arlen !== obs_arlen ||
          axi.arburst !== obs_arburst) ar_stable = 1'b0;
    end
    axi.arready = 1'b1;
    @(posedge clk); #1;
    axi.arready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (gap && i > 0) begin
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        @(posedge clk); #1;
      end
      axi.rvalid = 1'b1;
      axi.rdata  = 32'(32'hA0 + i);
      axi.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      axi.rlast  = (i == last_beat);
      if (axi.rready !== 1'b1) not_ready_beats++;
      @(posedge clk); #1;
      if (i == abort_at) begin
        rst = 1'b0;
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        return;
      end
    end
    rready_after = axi.rready;
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    t = 0;
    while (done_cnt == done_base && t < 10) begin
      @(negedge clk); #1; t++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++;
    if ((|{miss_ready, axi.arvalid, axi.rready, ram_en, ram_wen, crit_valid, refill_done,
           refill_err, refill_index, axi.araddr, axi.arlen, axi.arsize, axi.arburst}) !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero, required all 0");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (miss_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b, required 1", miss_ready);
    end
  endtask

  task automatic check_line(input string nm, input logic [31:0] a, input int nwr,
                            input bit exp_err, input bit exp_crit);
    int start, cbeat;
    logic [7:0] exp_en;
    start = Cwf ? int'(a[4:2]) : 0;
    cbeat = (int'(a[4:2]) - start + 8) % 8;
    n_checks++;
    if (wr_cnt - wr_base !== nwr) begin
      n_fail++; $display("FAIL %s_write_count: got %0d, required %0d", nm, wr_cnt - wr_base, nwr);
    end
    for (int i = 0; i < nwr && i < wr_cnt - wr_base; i++) begin
      exp_en = 8'b1 << ((start + i) % 8);
      n_checks++;
      if (wr_en[wr_base + i] !== exp_en || wr_data[wr_base + i] !== 32'(32'hA0 + i) ||
          wr_idx[wr_base + i] !== a[11:5] || wr_wen[wr_base + i] !== 4'hF) begin
        n_fail++;
        $display("FAIL %s_write%0d: en=%h data=%h idx=%h wen=%h, required en=%h data=%h idx=%h wen=f",
                 nm, i, wr_en[wr_base + i], wr_data[wr_base + i], wr_idx[wr_base + i],
                 wr_wen[wr_base + i], exp_en, 32'hA0 + i, a[11:5]);
      end
    end
    if (exp_crit) begin
      n_checks++;
      if (crit_cnt - crit_base !== 1 || crit_d !== 32'(32'hA0 + cbeat) ||
          crit_pos !== wr_base + cbeat) begin
        n_fail++;
        $display("FAIL %s_crit: pulses=%0d data=%h at_write=%0d, required 1 %h %0d", nm,
                 crit_cnt - crit_base, crit_d, crit_pos - wr_base, 32'hA0 + cbeat, cbeat);
      end
    end
    n_checks++;
    if (done_cnt - done_base !== 1 || done_err !== exp_err || done_idx !== a[11:5] ||
        !done_wr || done_pos !== wr_base + nwr - 1) begin
      n_fail++;
      $display("FAIL %s_done: pulses=%0d err=%b idx=%h with_write=%b at=%0d, required 1 %b %h 1 %0d",
               nm, done_cnt - done_base, done_err, done_idx, done_wr, done_pos - wr_base,
               exp_err, a[11:5], nwr - 1);
    end
  endtask

  task automatic test_basic(input logic [31:0] a);
    logic [31:0] exp_araddr;
    exp_araddr = Cwf ? (a & ~32'h3) : (a & ~32'h1F);
    do_refill(a, 0, 1'b0, -1, 7, 8, -1);
    n_checks++;
    if (obs_araddr !== exp_araddr || obs_arlen !== 8'd7 || obs_arsize !== 3'b010 ||
        obs_arburst !== (Cwf ? 2'b10 : 2'b01)) begin
      n_fail++;
      $display("FAIL basic_ar: araddr=%h arlen=%0d arsize=%b arburst=%b, required %h 7 010 %b",
               obs_araddr, obs_arlen, obs_arsize, obs_arburst, exp_araddr, Cwf ? 2'b10 : 2'b01);
    end
    check_line("basic", a, 8, 1'b0, 1'b1);
  endtask

  task automatic test_spec_vector();
    do_refill(32'h0000_1A4C, 0, 1'b0, -1, 7, 8, -1);
    n_checks++;
    if (obs_araddr !== (Cwf ? 32'h0000_1A4C : 32'h0000_1A40) || done_idx !== 7'h52 ||
        crit_d !== (Cwf ? 32'hA0 : 32'hA3)) begin
      n_fail++;
      $display("FAIL vector_1a4c: araddr=%h idx=%h crit=%h", obs_araddr, done_idx, crit_d);
    end
    check_line("vector", 32'h0000_1A4C, 8, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    do_refill(32'h0000_1A4C, 5, 1'b1, -1, 7, 8, -1);
    n_checks++;
    if (!ar_stable || not_ready_beats != 0) begin
      n_fail++;
      $display("FAIL bp_ar_stable: stable=%b unready_beats=%0d, required 1 0", ar_stable,
               not_ready_beats);
    end
    check_line("bp", 32'h0000_1A4C, 8, 1'b0, 1'b1);
  endtask

  task automatic test_err_beat();
    do_refill(32'h0000_2FF8, 0, 1'b0, 2, 7, 8, -1);
    check_line("errbeat", 32'h0000_2FF8, 8, 1'b1, 1'b1);
  endtask

  task automatic test_early_rlast();
    do_refill(32'h0000_0100, 0, 1'b0, -1, 5, 6, -1);
    check_line("early", 32'h0000_0100, 6, 1'b1, 1'b1);
  endtask

  task automatic test_missing_rlast();
    do_refill(32'h0000_0FE0, 0, 1'b0, -1, -1, 8, -1);
    n_checks++;
    if (rready_after !== 1'b0) begin
      n_fail++; $display("FAIL missing_rready: got %b after 8 beats, required 0", rready_after);
    end
    check_line("missing", 32'h0000_0FE0, 8, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_rd();
    do_refill(32'h0000_1A4C, 0, 1'b0, -1, 7, 8, 3);
    #1;
    n_checks++;
    if ((|{miss_ready, axi.arvalid, axi.rready, ram_en, ram_wen, crit_valid, refill_done,
           refill_err, refill_index}) !== 1'b0) begin
      n_fail++; $display("FAIL midrd_async: some output nonzero while rst low, required all 0");
    end
    @(posedge clk); #1;
    n_checks++;
    if ((|{miss_ready, axi.arvalid, axi.rready, ram_en, crit_valid, refill_done}) !== 1'b0) begin
      n_fail++; $display("FAIL midrd_edge: some output nonzero at edge in reset, required all 0");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (miss_ready !== 1'b1 || axi.arvalid !== 1'b0 || axi.rready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrd_idle: ready=%b arvalid=%b rready=%b, required 1 0 0", miss_ready,
               axi.arvalid, axi.rready);
    end
    test_basic(32'h0000_0104);
  endtask

  initial begin
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    test_reset();
    test_spec_vector();
    test_basic(32'h0000_2FF8);
    test_backpressure();
    test_err_beat();
    test_early_rlast();
    test_missing_rlast();
    test_reset_mid_rd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
Miss-refill engine for the instruction cache, directly upstream of the per-word icache data RAM banks. It accepts one line miss and issues a single AXI4 read burst. Each returned beat is written into the matching word bank at set index addr[11:5]. It forwards the missed (critical) word to fetch and pulses completion so the tag array can be updated.

Parameters:
LINE_WORDS, 8, words per cache line (power of 2; one data RAM bank per word)
INDEX_LSB, 5, lowest set-index bit (log2 of line bytes)
INDEX_W, 7, set-index width (addr[11:5])

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (0 = reset)
miss_valid  in  1  miss request
miss_addr  in  32  missing fetch byte address
miss_ready  out  1  engine idle, request accepted this cycle
arvalid  out  1  AXI read-address valid
arready  in  1  AXI read-address ready
araddr  out  32  burst start address
arlen  out  8  beats minus 1
arsize  out  3  fixed 3'b010 (4 bytes)
arburst  out  2  burst type
rvalid  in  1  AXI read-data valid
rready  out  1  AXI read-data ready
rdata  in  32  beat data
rresp  in  2  beat response
rlast  in  1  last beat
ram_en  out  LINE_WORDS  one-hot bank enable
ram_wen  out  4  byte write enable (4'hF when writing, else 0)
ram_addr  out  32  line address to banks (only [11:5] consumed)
ram_wdata  out  32  word to write
crit_valid  out  1  one-cycle pulse: critical word available
crit_data  out  32  critical word
refill_done  out  1  one-cycle pulse: line fully written
refill_err  out  1  valid with refill_done: bad rresp or beat-count mismatch
refill_index  out  INDEX_W  set index of completed line (valid with refill_done)

Behaviour:
- rst low (any cycle, async): state IDLE; every output 0 (miss_ready 0 while rst low); counters and err flag cleared. A burst abandoned mid-flight is not drained; a global reset is assumed.
- States: IDLE, AR, RD, DONE.
- IDLE: miss_ready=1. On miss_valid&&miss_ready, latch miss_addr and go to AR. No new miss is accepted until back in IDLE.
- AR: arvalid=1; araddr/arlen/arsize/arburst are registered and held stable until arready. arlen=LINE_WORDS-1. On arvalid&&arready, go to RD.
- RD: rready=1.
  - Each beat (rvalid&&rready) registers a RAM write for the next cycle: ram_en one-hot[bank], ram_wen=4'hF, ram_wdata=rdata, ram_addr = latched line base. Latency is 1 cycle, one write per beat.
  - bank counter (log2 LINE_WORDS bits) increments per beat and wraps modulo LINE_WORDS.
  - crit_valid/crit_data are registered and pulse for 1 cycle, aligned with the RAM write of the beat whose bank equals miss_addr[4:2].
  - rresp != 2'b00 sets a sticky err.
  - On rlast, go to DONE. err is also set if the beat count != LINE_WORDS; if LINE_WORDS beats arrive without rlast, rready is dropped and the block goes to DONE with err.
- DONE: 1 cycle. refill_done=1, refill_err=err, refill_index=latched addr[11:5]. This cycle coincides with the last RAM write. Then go to IDLE.
- ram_en, crit_valid and refill_done are 0 in every cycle not listed above.

Optional Feature:
ICACHE_CRIT_WORD_FIRST_EN
- Defined: araddr = miss_addr & ~32'h3; arburst=2'b10 (WRAP); bank counter starts at miss_addr[4:2]. The critical word is therefore beat 0, and crit_valid fires in the cycle after the first beat.
- Undefined: araddr = miss_addr with bits [4:0] cleared; arburst=2'b01 (INCR); counter starts at 0. crit_valid fires on the write of beat miss_addr[4:2].
- All other behaviour is identical in both builds.

Decomposition:
- Shared package icache_pkg holds:
  - LINE_WORDS, OFFSET_W, INDEX_W, INDEX_LSB
  - AXI constants: BURST_INCR=2'b01, BURST_WRAP=2'b10, RESP_OKAY=2'b00, SIZE_4B=3'b010
  - refill state enum
- No sub-module is required; the single FSM plus bank counter fits in one module.

Test Plan:
- Reset mid-RD: pull rst low after beat 3 -> next edge all outputs 0, state IDLE; after release, miss_ready=1 and a new miss completes normally.
- Basic INCR, miss_addr=32'h0000_1A4C, arready immediate, 8 beats 32'hA0..A7, one beat per cycle:
  - araddr=32'h1A40, arlen=7, arburst=01
  - ram_en steps 0x01..0x80 with ram_addr[11:5]=7'h52
  - crit_data=32'hA3
  - refill_done with refill_index=7'h52, refill_err=0
- Backpressure: arready delayed 5 cycles -> araddr/arlen stable throughout; rvalid gapped every other cycle -> exactly 8 RAM writes, no extra ram_en pulses.
- Error beat: rresp=2'b10 on beat 2 -> all 8 words still written, refill_done with refill_err=1.
- Early rlast on beat 5 -> 6 writes, DONE, refill_err=1. Missing rlast after 8 beats -> rready drops, refill_err=1.
- With ICACHE_CRIT_WORD_FIRST_EN, miss_addr=32'h1A4C:
  - araddr=32'h1A4C, arburst=10
  - first write to bank 3, order 3,4..7,0..2
  - crit_valid in the cycle after beat 0, crit_data = beat-0 data
